// File: rtl/button_event_unit.sv
// Per-button sync, optional debounce, edge/level event detect, sticky capture and saturating counters.
// Latency: 3 clk from raw input to capture/data with debounce off, count 1 clk after counter; no backpressure.
module button_event_unit #(
    parameter  int NUM_BUTTONS  = 8,
    parameter  int DATA_WIDTH   = 32,
    parameter  int DEBOUNCE_CNT = 4,
    parameter  int CNT_WIDTH    = 8,
    localparam int SEL_W        = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_div,
    input  logic [NUM_BUTTONS-1:0]   button,
    input  logic [NUM_BUTTONS-1:0]   clr,
    input  logic [NUM_BUTTONS-1:0]   en_noise_cancelling,
    input  logic [2*NUM_BUTTONS-1:0] select_edge,
    input  logic [SEL_W-1:0]         rd_sel,
    output logic [DATA_WIDTH-1:0]    data,
    output logic [CNT_WIDTH-1:0]     count,
    output logic                     irq
);
    localparam int DBW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DBW-1:0]       DB_LAST = DBW'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [NUM_BUTTONS-1:0] s1, s2, stable, en_q, capture;
    logic [DBW-1:0]         db_cnt [NUM_BUTTONS];
    logic [CNT_WIDTH-1:0]   ev_cnt [NUM_BUTTONS];

    logic [NUM_BUTTONS-1:0] stable_nxt, rise, fall, ev, cap_nxt;
    logic [DBW-1:0]         db_nxt  [NUM_BUTTONS];
    logic [CNT_WIDTH-1:0]   cnt_nxt [NUM_BUTTONS];
    logic [CNT_WIDTH-1:0]   count_nxt;

    always_comb begin
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            stable_nxt[i] = stable[i];
            db_nxt[i]     = db_cnt[i];
            if (!en_noise_cancelling[i]) begin
                stable_nxt[i] = s2[i];
                db_nxt[i]     = '0;
            end else if (clk_div) begin
                if (s2[i] == stable[i]) begin
                    db_nxt[i] = '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable_nxt[i] = s2[i];
                    db_nxt[i]     = '0;
                end else begin
                    db_nxt[i] = db_cnt[i] + 1'b1;
                end
            end
            // Any change of the enable restarts debounce progress.
            if (en_noise_cancelling[i] != en_q[i]) begin
                db_nxt[i] = '0;
            end

            // Events fire on the edge where stable is about to change, so capture lands with stable.
            rise[i] = stable_nxt[i] & ~stable[i];
            fall[i] = ~stable_nxt[i] & stable[i];
            case (select_edge[2*i +: 2])
                2'b00:   ev[i] = rise[i];
                2'b01:   ev[i] = fall[i];
                2'b10:   ev[i] = rise[i] | fall[i];
                default: ev[i] = rise[i];
            endcase

            if (select_edge[2*i +: 2] == 2'b11) begin
                cap_nxt[i] = stable[i];
            end else if (ev[i]) begin
                cap_nxt[i] = 1'b1;
            end else if (clr[i]) begin
                cap_nxt[i] = 1'b0;
            end else begin
                cap_nxt[i] = capture[i];
            end

            cnt_nxt[i] = ev_cnt[i];
            if (clr[i]) begin
                cnt_nxt[i] = ev[i] ? CNT_WIDTH'(1) : '0;
            end else if (ev[i] && ev_cnt[i] != CNT_MAX) begin
                cnt_nxt[i] = ev_cnt[i] + 1'b1;
            end
        end

        count_nxt = '0;
        if (int'(rd_sel) < NUM_BUTTONS) begin
            count_nxt = ev_cnt[rd_sel];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            stable  <= '0;
            en_q    <= '0;
            capture <= '0;
            count   <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                db_cnt[i] <= '0;
                ev_cnt[i] <= '0;
            end
        end else begin
            s1      <= button;
            s2      <= s1;
            stable  <= stable_nxt;
            en_q    <= en_noise_cancelling;
            capture <= cap_nxt;
            count   <= count_nxt;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                db_cnt[i] <= db_nxt[i];
                ev_cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign data = DATA_WIDTH'(capture);
    assign irq  = |capture;
endmodule

// File: tb/tb_button_event_unit.sv
// Directed bench: a full-size unit plus a 6-channel, 2-bit-counter unit sharing the same stimulus.
module tb_button_event_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        clk_div;
    logic [7:0]  button, clr, en_nc;
    logic [15:0] select_edge;
    logic [2:0]  rd_sel;
    logic [31:0] data, data_s;
    logic [7:0]  count;
    logic [1:0]  count_s;
    logic        irq, irq_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    button_event_unit #(.NUM_BUTTONS(8), .DATA_WIDTH(32), .DEBOUNCE_CNT(4), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .clk_div(clk_div), .button(button), .clr(clr),
        .en_noise_cancelling(en_nc), .select_edge(select_edge), .rd_sel(rd_sel),
        .data(data), .count(count), .irq(irq)
    );

    button_event_unit #(.NUM_BUTTONS(6), .DATA_WIDTH(32), .DEBOUNCE_CNT(4), .CNT_WIDTH(2)) dut_s (
        .clk(clk), .rst(rst), .clk_div(clk_div), .button(button[5:0]), .clr(clr[5:0]),
        .en_noise_cancelling(en_nc[5:0]), .select_edge(select_edge[11:0]), .rd_sel(rd_sel),
        .data(data_s), .count(count_s), .irq(irq_s)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One clk_div period: three quiet clocks, then a one-clock tick.
    task automatic div_period();
        clk_div = 1'b0;
        step(3);
        clk_div = 1'b1;
        step(1);
        clk_div = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; clk_div = 1'b0; button = '0; clr = '0; en_nc = '0; rd_sel = '0;
        select_edge = 16'h0308;  // ch1 both edges, ch4 level-high, others rising
        step(3);
        rst = 1'b0;
        step(1);
        check("reset_data", data, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        check("reset_count", {24'b0, count}, 32'h0);

        // Rising edge on ch0, debounce off: capture on the third edge.
        button[0] = 1'b1;
        step(2);
        check("ch0_not_yet", data, 32'h0);
        step(1);
        check("ch0_data", data, 32'h1);
        check("ch0_irq", {31'b0, irq}, 32'h1);
        step(1);
        check("ch0_count", {24'b0, count}, 32'h1);
        clr[0] = 1'b1; step(1); clr[0] = 1'b0;
        check("ch0_clr", data, 32'h0);
        check("irq_low", {31'b0, irq}, 32'h0);

        // Debounce on ch2: 2 ticks high, 1 tick low, then steady high.
        en_nc[2] = 1'b1;
        step(2);
        button[2] = 1'b1;
        div_period(); div_period();
        button[2] = 1'b0;
        div_period();
        button[2] = 1'b1;
        div_period(); div_period(); div_period();
        check("db_three_ticks", data, 32'h0);
        div_period();
        check("db_accept", data, 32'h4);
        rd_sel = 3'd2;
        step(1);
        check("db_count", {24'b0, count}, 32'h1);

        // Ch1 both edges: 5 pulses give 10 events.
        for (int k = 0; k < 5; k++) begin
            button[1] = 1'b1; step(3);
            button[1] = 1'b0; step(3);
        end
        step(2);
        rd_sel = 3'd1;
        step(1);
        check("ch1_data", data, 32'h6);
        check("ch1_count", {24'b0, count}, 32'd10);
        check("ch1_count_sat", {30'b0, count_s}, 32'd3);
        clr[1] = 1'b1; step(1); clr[1] = 1'b0;
        check("ch1_clr_data", data, 32'h4);
        step(1);
        check("ch1_clr_count", {24'b0, count}, 32'h0);

        // Ch3: clr coincides with the rising event.
        rd_sel = 3'd3;
        button[3] = 1'b1;
        step(2);
        clr[3] = 1'b1; step(1); clr[3] = 1'b0;
        check("ch3_set_wins", data, 32'hC);
        step(1);
        check("ch3_count", {24'b0, count}, 32'h1);
        check("ch3_count_s", {30'b0, count_s}, 32'h1);

        // Ch0: 6 rising edges saturate the 2-bit counter.
        for (int k = 0; k < 6; k++) begin
            button[0] = 1'b0; step(3);
            button[0] = 1'b1; step(3);
        end
        rd_sel = 3'd0;
        step(1);
        check("ch0_count6", {24'b0, count}, 32'd6);
        check("ch0_sat3", {30'b0, count_s}, 32'd3);
        check("ch0_recapt", data, 32'hD);

        // Ch4 level mode: capture follows stable one clk later.
        rd_sel = 3'd4;
        button[4] = 1'b1;
        step(3);
        check("ch4_lag", data, 32'hD);
        step(1);
        check("ch4_high", data, 32'h1D);
        check("ch4_count", {24'b0, count}, 32'h1);
        clr[4] = 1'b1; step(1); clr[4] = 1'b0;
        check("ch4_clr_ignored", data, 32'h1D);
        button[4] = 1'b0;
        step(4);
        check("ch4_low", data, 32'hD);

        // Out-of-range read on the 6-channel unit while counters are nonzero.
        rd_sel = 3'd6;
        step(1);
        check("rdsel_oor", {30'b0, count_s}, 32'h0);

        // Reset in the middle of a debounce with live counters.
        rd_sel = 3'd0;
        button[2] = 1'b0;
        div_period(); div_period();
        check("pre_rst_count", {24'b0, count}, 32'd6);
        rst = 1'b1;
        step(1);
        check("rst_data", data, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_count", {24'b0, count}, 32'h0);
        check("rst_data_s", data_s, 32'h0);
        check("rst_count_s", {30'b0, count_s}, 32'h0);
        rst = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
